// File: rtl/fb_pkg.sv
// Frame-buffer types, default palette and default 640x480 timing, shared with the PRU.
package fb_pkg;

  typedef logic [1:0]  color_idx_t;
  typedef logic [11:0] rgb12_t;
  typedef logic [9:0]  fb_x_t;
  typedef logic [8:0]  fb_y_t;

  typedef enum logic {StIdle, StScan} scan_state_t;

  localparam rgb12_t PAL_DEF0 = 12'h000;
  localparam rgb12_t PAL_DEF1 = 12'hFFF;
  localparam rgb12_t PAL_DEF2 = 12'hF00;
  localparam rgb12_t PAL_DEF3 = 12'h00F;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

endpackage

// File: rtl/scan_timing.sv
// Raster h/v counters with undelayed de/hs/vs (active-high), vblank and frame-start pulse.
module scan_timing
  import fb_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic       enable,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       de,
  output logic       hs,
  output logic       vs,
  output logic       vblank,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  scan_state_t state_q, state_d;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        fs_q, fs_d;
  logic        scanning;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fs_q    <= fs_d;
    end
  end

  // The idle->scan tick enters (0,0) without consuming it, so the pulse precedes the first read.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    fs_d    = 1'b0;
    if (pix_ce) begin
      if (!enable) begin
        state_d = StIdle;
        h_d     = '0;
        v_d     = '0;
      end else begin
        case (state_q)
          StIdle: begin
            state_d = StScan;
            h_d     = '0;
            v_d     = '0;
            fs_d    = 1'b1;
          end
          StScan: begin
            if (h_q == H_LAST) begin
              h_d = '0;
              if (v_q == V_LAST) begin
                v_d  = '0;
                fs_d = 1'b1;
              end else begin
                v_d = v_q + 10'd1;
              end
            end else begin
              h_d = h_q + 10'd1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  assign scanning    = (state_q == StScan);
  assign h           = h_q;
  assign v           = v_q;
  assign de          = scanning && (h_q < H_ACT) && (v_q < V_ACT);
  assign hs          = scanning && (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs          = scanning && (v_q >= VS_BEG) && (v_q < VS_END);
  assign vblank      = (v_q >= V_ACT);
  assign frame_start = fs_q;

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: read strobe, 2-stage index->palette pipeline and VGA outputs.
// FB_SCANOUT_SCALE2X_EN selects line/pixel-doubled addressing of a 320x240 source.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic       enable,
  output logic       fb_rd_en,
  output fb_x_t      fb_rd_x,
  output fb_y_t      fb_rd_y,
  input  color_idx_t fb_rd_data,
  input  logic       pal_wr_en,
  input  color_idx_t pal_wr_idx,
  input  rgb12_t     pal_wr_rgb,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_de,
  output logic       vblank,
  output logic       frame_start
);

  logic [9:0] h, v;
  logic       de0, hs0, vs0;

  scan_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_ce      (pix_ce),
    .enable      (enable),
    .h           (h),
    .v           (v),
    .de          (de0),
    .hs          (hs0),
    .vs          (vs0),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

`ifdef FB_SCANOUT_SCALE2X_EN
  // Odd pixels skip the read; the memory keeps presenting the even pixel's index.
  assign fb_rd_en = pix_ce & enable & de0 & ~h[0];
  assign fb_rd_x  = fb_x_t'(h >> 1);
  assign fb_rd_y  = fb_y_t'(v >> 1);
`else
  assign fb_rd_en = pix_ce & enable & de0;
  assign fb_rd_x  = fb_x_t'(h);
  assign fb_rd_y  = fb_y_t'(v);
`endif

  // Stage 1 is the memory's own output register; only the timing flags are delayed here.
  logic   de1_q, hs1_q, vs1_q;
  logic   de2_q, hs2_q, vs2_q;
  rgb12_t rgb_q;
  rgb12_t pal_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      de1_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      de2_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      rgb_q <= '0;
    end else if (pix_ce) begin
      if (!enable) begin
        de1_q <= 1'b0;
        hs1_q <= 1'b0;
        vs1_q <= 1'b0;
        de2_q <= 1'b0;
        hs2_q <= 1'b0;
        vs2_q <= 1'b0;
        rgb_q <= '0;
      end else begin
        de1_q <= de0;
        hs1_q <= hs0;
        vs1_q <= vs0;
        de2_q <= de1_q;
        hs2_q <= hs1_q;
        vs2_q <= vs1_q;
        rgb_q <= de1_q ? pal_q[fb_rd_data] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pal_q[0] <= PAL_DEF0;
      pal_q[1] <= PAL_DEF1;
      pal_q[2] <= PAL_DEF2;
      pal_q[3] <= PAL_DEF3;
    end else if (pal_wr_en) begin
      pal_q[pal_wr_idx] <= pal_wr_rgb;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_de = de2_q;
  assign vga_hs = hs2_q ? HS_POL : ~HS_POL;
  assign vga_vs = vs2_q ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: raster-position reference model plus directed timing and pixel checks.
module tb_fb_scanout;

  localparam int HA = 640, HFP = 16, HSW = 96, HBP = 48;
  localparam int VA = 6, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;

`ifdef FB_SCANOUT_SCALE2X_EN
  localparam int PX1_H = 16, PX2_H = 104;
`else
  localparam int PX1_H = 22, PX2_H = 102;
`endif

  logic        clk = 1'b0;
  logic        rst, pix_ce, enable;
  logic        fb_rd_en;
  logic [9:0]  fb_rd_x;
  logic [8:0]  fb_rd_y;
  logic [1:0]  fb_rd_data = 2'b00;
  logic        pal_wr_en;
  logic [1:0]  pal_wr_idx;
  logic [11:0] pal_wr_rgb;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de, vblank, frame_start;

  fb_scanout #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .HS_POL   (1'b0), .VS_POL (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_ce      (pix_ce),
    .enable      (enable),
    .fb_rd_en    (fb_rd_en),
    .fb_rd_x     (fb_rd_x),
    .fb_rd_y     (fb_rd_y),
    .fb_rd_data  (fb_rd_data),
    .pal_wr_en   (pal_wr_en),
    .pal_wr_idx  (pal_wr_idx),
    .pal_wr_rgb  (pal_wr_rgb),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_de      (vga_de),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Registered frame buffer whose content is (x+y)%4.
  always @(posedge clk) begin
    if (fb_rd_en) fb_rd_data <= 2'((int'(fb_rd_x) + int'(fb_rd_y)) % 4);
  end

  int checks = 0, errors = 0;
  bit live = 1'b0;

  // Reference: scan position since frame start plus a two-tick output delay line.
  typedef struct packed {logic de; logic hs; logic vs; logic [1:0] idx;} rec_t;
  bit          m_run = 1'b0;
  int          m_pos = 0;
  bit          m_fs  = 1'b0;
  rec_t        m_pend = '0;
  logic        m_de = 1'b0, m_hs = 1'b0, m_vs = 1'b0;
  logic [11:0] m_rgb = '0;
  logic [11:0] m_pal [4];

  int clk_cnt = 0, last_fs = -1, fs_p = 0;
  int hs_run = 0, hs_w = 0, vs_run = 0, vs_w = 0, de_run = 0, de_w = 0;

  function automatic rec_t rec_of(input int pos);
    rec_t r;
    int h, v;
    h = pos % HT;
    v = pos / HT;
    r.de = (h < HA) && (v < VA);
    r.hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
    r.vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
`ifdef FB_SCANOUT_SCALE2X_EN
    r.idx = 2'((h / 2 + v / 2) % 4);
`else
    r.idx = 2'((h + v) % 4);
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_run = 1'b0; m_pos = 0; m_fs = 1'b0; m_pend = '0;
      m_de = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_rgb = '0;
      m_pal[0] = 12'h000; m_pal[1] = 12'hFFF; m_pal[2] = 12'hF00; m_pal[3] = 12'h00F;
    end else begin
      m_fs = 1'b0;
      if (pix_ce) begin
        if (!enable) begin
          m_run = 1'b0; m_pos = 0; m_pend = '0;
          m_de = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_rgb = '0;
        end else begin
          m_de  = m_pend.de;
          m_hs  = m_pend.hs;
          m_vs  = m_pend.vs;
          m_rgb = m_pend.de ? m_pal[m_pend.idx] : 12'h000;
          m_pend = m_run ? rec_of(m_pos) : '0;
          if (!m_run) begin
            m_run = 1'b1; m_pos = 0; m_fs = 1'b1;
          end else begin
            m_pos = (m_pos + 1) % FT;
            m_fs  = (m_pos == 0);
          end
        end
      end
      if (pal_wr_en) m_pal[pal_wr_idx] = pal_wr_rgb;
    end
  endtask

  task automatic step();
    int h, v, xe, ye;
    bit en_e;
    #1;
    h = m_run ? m_pos % HT : 0;
    v = m_run ? m_pos / HT : 0;
`ifdef FB_SCANOUT_SCALE2X_EN
    xe = h / 2; ye = v / 2;
    en_e = pix_ce && enable && m_run && (h < HA) && (v < VA) && (h % 2 == 0);
`else
    xe = h; ye = v;
    en_e = pix_ce && enable && m_run && (h < HA) && (v < VA);
`endif
    if (live) begin
      chk("rd_en", 32'(fb_rd_en), 32'(en_e));
      chk("rd_x", 32'(fb_rd_x), 32'(xe));
      chk("rd_y", 32'(fb_rd_y), 32'(ye));
      chk("vblank", 32'(vblank), 32'(v >= VA));
    end
    @(posedge clk);
    #1;
    model_edge();
    if (rst) live = 1'b1;
    clk_cnt++;
    if (vga_hs == 1'b0) hs_run++; else begin if (hs_run > 0) hs_w = hs_run; hs_run = 0; end
    if (vga_vs == 1'b0) vs_run++; else begin if (vs_run > 0) vs_w = vs_run; vs_run = 0; end
    if (vga_de == 1'b1) de_run++; else begin if (de_run > 0) de_w = de_run; de_run = 0; end
    if (frame_start) begin
      if (last_fs >= 0) fs_p = clk_cnt - last_fs;
      last_fs = clk_cnt;
    end
    chk("de", 32'(vga_de), 32'(m_de));
    chk("hs", 32'(vga_hs), 32'(!m_hs));
    chk("vs", 32'(vga_vs), 32'(!m_vs));
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(m_rgb));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  task automatic run_until(input int h, input int v, input string tag);
    int n = 0;
    while (!(m_run && m_pos == v * HT + h) && n < 2 * FT) begin
      step();
      n++;
    end
    if (n >= 2 * FT) begin
      checks++;
      errors++;
      $error("FAIL %s: timeout waiting for (%0d,%0d)", tag, h, v);
    end
  endtask

  initial begin
    rst = 1'b1; pix_ce = 1'b0; enable = 1'b0;
    pal_wr_en = 1'b0; pal_wr_idx = 2'd0; pal_wr_rgb = 12'h000;
    step();
    step();
    chk("rst_de", 32'(vga_de), 32'd0);
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("rst_hs", 32'(vga_hs), 32'd1);
    chk("rst_vs", 32'(vga_vs), 32'd1);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_vblank", 32'(vblank), 32'd0);

    // Full rate: pixel mapping, mid-line palette write, line/frame timing.
    rst = 1'b0; enable = 1'b1; pix_ce = 1'b1;
    hs_w = 0; vs_w = 0; de_w = 0; fs_p = 0;
    step();
    chk("first_fs", 32'(frame_start), 32'd1);
    run_until(11, 3, "find_px11");
    chk("px11_rd_en", 32'(fb_rd_en), 32'd1);
    step();
    step();
    chk("px11_de", 32'(vga_de), 32'd1);
    chk("px11_rgb", 32'({vga_r, vga_g, vga_b}), 32'hF00);
    run_until(PX1_H, 3, "find_px1");
    step();
    step();
    chk("pal_old", 32'({vga_r, vga_g, vga_b}), 32'hFFF);
    pal_wr_en = 1'b1; pal_wr_idx = 2'd1; pal_wr_rgb = 12'h0A5;
    step();
    pal_wr_en = 1'b0;
    run_until(PX2_H, 3, "find_px2");
    step();
    step();
    chk("pal_new", 32'({vga_r, vga_g, vga_b}), 32'h0A5);
    repeat (2 * FT + 200) step();
    chk("hs_width", 32'(hs_w), 32'(HSW));
    chk("vs_width", 32'(vs_w), 32'(VSW * HT));
    chk("de_width", 32'(de_w), 32'(HA));
    chk("fs_period", 32'(fs_p), 32'(FT));

    // Half rate: every width doubles in clocks.
    hs_w = 0; de_w = 0;
    for (int i = 0; i < 4 * HT; i++) begin
      pix_ce = (i % 2 == 1);
      step();
    end
    chk("hs_width_half", 32'(hs_w), 32'(2 * HSW));
    chk("de_width_half", 32'(de_w), 32'(2 * HA));

    // Random pix_ce, enable glitches and palette writes against the model.
    for (int i = 0; i < 8000; i++) begin
      pix_ce     = ($urandom % 3) != 0;
      enable     = ($urandom % 400) != 0;
      pal_wr_en  = ($urandom % 64) == 0;
      pal_wr_idx = 2'($urandom);
      pal_wr_rgb = 12'($urandom);
      step();
    end
    pix_ce = 1'b1; enable = 1'b1; pal_wr_en = 1'b0;

    // Reset mid-frame.
    run_until(300, 4, "find_rst_pt");
    rst = 1'b1;
    step();
    chk("mid_rst_de", 32'(vga_de), 32'd0);
    chk("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("mid_rst_hs", 32'(vga_hs), 32'd1);
    chk("mid_rst_vs", 32'(vga_vs), 32'd1);
    chk("mid_rst_fs", 32'(frame_start), 32'd0);
    chk("mid_rst_vblank", 32'(vblank), 32'd0);
    chk("mid_rst_rd_en", 32'(fb_rd_en), 32'd0);
    rst = 1'b0;
    step();
    chk("rel_fs", 32'(frame_start), 32'd1);
    chk("rel_rd_en", 32'(fb_rd_en), 32'd1);
    chk("rel_rd_xy", 32'({fb_rd_x, fb_rd_y}), 32'd0);
    run_until(PX1_H, 3, "find_pal_def");
    step();
    step();
    chk("pal_restored", 32'({vga_r, vga_g, vga_b}), 32'hFFF);

    // Enable dropped mid-line, then restored.
    run_until(200, 1, "find_dis_pt");
    enable = 1'b0;
    #1;
    chk("dis_rd_en", 32'(fb_rd_en), 32'd0);
    step();
    step();
    chk("dis_de", 32'(vga_de), 32'd0);
    chk("dis_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    for (int i = 0; i < 20; i++) begin
      pix_ce = 1'($urandom);
      step();
    end
    pix_ce = 1'b1;
    enable = 1'b1;
    step();
    chk("reen_fs", 32'(frame_start), 32'd1);
    chk("reen_rd_en", 32'(fb_rd_en), 32'd1);
    chk("reen_rd_x0", 32'(fb_rd_x), 32'd0);
`ifdef FB_SCANOUT_SCALE2X_EN
    step();
    chk("s2x_odd_rd_en", 32'(fb_rd_en), 32'd0);
    step();
    chk("s2x_rd_x1", 32'(fb_rd_x), 32'd1);
    chk("s2x_rd_en2", 32'(fb_rd_en), 32'd1);
    step();
    step();
    chk("s2x_rd_x2", 32'(fb_rd_x), 32'd2);
`else
    step();
    chk("reen_rd_x1", 32'(fb_rd_x), 32'd1);
`endif
    repeat (1000) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
